// File: rtl/stackcalc_sequencer_if.sv
// Host-side program/control bus of the stackcalc sequencer.
interface stackcalc_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [3:0]        prog_data;
  logic [ADDR_W:0]   prog_len;
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic              step_valid;
  logic [ADDR_W-1:0] step_pc;
  logic [7:0]        result;

  modport master (
    output prog_we, prog_addr, prog_data, prog_len, start, abort,
    input  busy, done, step_valid, step_pc, result
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, prog_len, start, abort,
    output busy, done, step_valid, step_pc, result
  );
endinterface

// File: rtl/stackcalc_sequencer.sv
// Plays a stored nibble program into the stackcalc core, generating its clock and reset.
// Optional STACKCALC_SEQ_LOOP_EN adds loop_en for continuous replay until abort.
module stackcalc_sequencer #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int HALF_PERIOD = 1,
  parameter int RST_CYCLES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  stackcalc_sequencer_if.slave bus,
`ifdef STACKCALC_SEQ_LOOP_EN
  input  logic                 loop_en,
`endif
  output logic [7:0]           calc_io_in,
  input  logic [7:0]           calc_io_out
);

  localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYCLES - 1);
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CRST_LO = 3'd1;
  localparam logic [2:0] S_CRST_HI = 3'd2;
  localparam logic [2:0] S_STEP_LO = 3'd3;
  localparam logic [2:0] S_STEP_HI = 3'd4;
  localparam logic [2:0] S_FIN     = 3'd5;

  logic [2:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W:0]   len;
  logic [CNT_W-1:0]  cnt;
  logic [RC_W-1:0]   rcnt;
  logic [7:0]        result_q;
  logic [3:0]        store [DEPTH];

  logic busy_i;
  logic phase_end;
  logic last_step;
  logic step_fire;
  logic loop_go;

  assign busy_i    = (state != S_IDLE) && (state != S_FIN);
  assign phase_end = (cnt == CNT_LAST);
  assign last_step = ({1'b0, pc} == (len - (ADDR_W + 1)'(1)));
  // An abort in the final HI cycle wins: that step is neither reported nor captured.
  assign step_fire = (state == S_STEP_HI) && phase_end && !bus.abort;

`ifdef STACKCALC_SEQ_LOOP_EN
  logic loop_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loop_q <= 1'b0;
    end else if (state == S_IDLE && bus.start) begin
      loop_q <= loop_en;
    end
  end

  // Dropping loop_en mid-run lets the current pass finish, then exits to FIN.
  assign loop_go = loop_q & loop_en;
`else
  assign loop_go = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        store[i] <= 4'h0;
      end
    end else if (state == S_IDLE && bus.prog_we) begin
      store[bus.prog_addr] <= bus.prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      pc    <= '0;
      len   <= '0;
      cnt   <= '0;
      rcnt  <= '0;
    end else if (busy_i && bus.abort) begin
      state <= S_IDLE;
      cnt   <= '0;
      rcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            len   <= (bus.prog_len > DEPTH_L) ? DEPTH_L : bus.prog_len;
            pc    <= '0;
            cnt   <= '0;
            rcnt  <= '0;
            state <= S_CRST_LO;
          end
        end
        S_CRST_LO: begin
          if (phase_end) begin
            cnt   <= '0;
            state <= S_CRST_HI;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_CRST_HI: begin
          if (phase_end) begin
            cnt <= '0;
            if (rcnt == RC_LAST) begin
              rcnt  <= '0;
              state <= (len == '0) ? S_FIN : S_STEP_LO;
            end else begin
              rcnt  <= rcnt + RC_W'(1);
              state <= S_CRST_LO;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_STEP_LO: begin
          if (phase_end) begin
            cnt   <= '0;
            state <= S_STEP_HI;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_STEP_HI: begin
          if (phase_end) begin
            cnt <= '0;
            if (last_step) begin
              if (loop_go) begin
                pc    <= '0;
                state <= S_STEP_LO;
              end else begin
                state <= S_FIN;
              end
            end else begin
              pc    <= pc + ADDR_W'(1);
              state <= S_STEP_LO;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q <= 8'h00;
    end else if (step_fire && last_step) begin
      result_q <= calc_io_out;
    end
  end

  // Decoded from state alone, so async reset forces 8'h02 (clock low) with no extra edge.
  always_comb begin
    calc_io_in = 8'h02;
    case (state)
      S_CRST_LO: calc_io_in = 8'h02;
      S_CRST_HI: calc_io_in = 8'h03;
      S_STEP_LO: calc_io_in = {2'b00, store[pc], 2'b00};
      S_STEP_HI: calc_io_in = {2'b00, store[pc], 2'b01};
      S_FIN:     calc_io_in = 8'h00;
      default:   calc_io_in = 8'h02;
    endcase
  end

  assign bus.busy       = busy_i;
  assign bus.done       = (state == S_FIN);
  assign bus.step_valid = step_fire;
  assign bus.step_pc    = pc;
  assign bus.result     = result_q;

endmodule
